muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the MIPS core.
- Executes MULT, MULTU, DIV and DIVU, and delivers the 2*WIDTH-bit result as a hi/lo write pair to the HI/LO register file directly downstream.
- Holds the pipeline via busy while it iterates. Produces exactly one write pulse per completed operation.

Parameters:
- WIDTH, 32, operand width and the width of each of hi and lo.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request: capture op/opa/opb. Accepted only while idle.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opa  input  WIDTH  multiplicand / dividend (rs).
- opb  input  WIDTH  multiplier / divisor (rt).
- cancel  input  1  pipeline flush: abort the in-flight operation with no write.
- busy  output  1  high whenever not in IDLE. Used as an EX stall.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU when opb==0.
- wehi  output  1  HI write enable, equal to done.
- wdatahi  output  WIDTH  HI write data. Valid while wehi=1, otherwise 0.
- welo  output  1  LO write enable, equal to done.
- wdatalo  output  WIDTH  LO write data. Valid while welo=1, otherwise 0.

Behaviour:
- States: IDLE, RUN, DONE. State, counter, accumulators and result registers are all on clk with async clear.
- Reset (any time, including mid-operation):
  - state=IDLE, all registers 0.
  - busy=done=div_by_zero=wehi=welo=0, wdatahi=wdatalo=0.
  - No write is issued for an interrupted operation.
- IDLE:
  - start=1 at edge E0 captures op, |opa|, |opb| (magnitudes for signed ops) and the operand signs.
  - Loads iteration counter with WIDTH-1 and enters RUN.
  - start=0 stays in IDLE.
  - cancel in IDLE has no effect; if start and cancel are both 1, start wins.
- RUN, one iteration per cycle, WIDTH iterations:
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division. Shift remainder left by one, trial-subtract the divisor, set the quotient bit if non-negative.
  - When the counter reaches 0, go to DONE.
  - Divide with opb==0 skips RUN and goes from IDLE straight to DONE: 1-cycle operation, done high in cycle E0+1.
- DONE, held exactly one cycle, then back to IDLE:
  - done=wehi=welo=1.
  - Multiply: {wdatahi,wdatalo} = product. For MULT, the product is negated when the operand signs differ (two's complement over 2*WIDTH).
  - Divide: wdatalo=quotient, wdatahi=remainder. For DIV, the quotient is negative iff the operand signs differ, and the remainder takes the sign of the dividend.
  - DIV of most-negative / -1: wdatalo=2^(WIDTH-1) (wraps), wdatahi=0.
  - Divide by zero: wdatalo=all ones, wdatahi=opa, div_by_zero=1.
- Latency:
  - Normal operation: done asserted in the cycle after the (WIDTH+1)-th edge following E0, i.e. 33 cycles after acceptance for WIDTH=32.
  - busy is high from E0 until the edge leaving DONE. A new start is accepted in the cycle after DONE at the earliest.
- start while busy: ignored. Operands are not re-captured and the in-flight operation is unaffected.
- cancel:
  - In RUN: return to IDLE at the next edge with no done/write pulse.
  - In DONE: ignored, and the write still occurs because the instruction has already retired past EX.
- Outputs are registered-state decodes. There are no combinational paths from start/opa/opb to any output.

Test Plan:
- MULT opa=0xFFFFFFFD (-3), opb=7 -> busy for 33 cycles, single pulse with wehi=welo=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU opa=opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> done and div_by_zero high in cycle E0+1, lo=0xFFFFFFFF, hi=5. Next start is accepted the following cycle.
- Start MULT, then pulse start with new operands at cycle 10, then a full run -> first result unchanged. Start DIV, cancel at cycle 20 -> idle the next cycle, no wehi/welo pulse.
- Assert rst_n=0 asynchronously mid-RUN (between edges) -> busy and all outputs 0 immediately. No write after release. A fresh MULTU 3*4 afterwards -> hi=0, lo=12.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage.
//
// Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands. The
// 2*WIDTH-bit result is delivered as a HI/LO write pair for exactly one
// cycle. The unit holds the pipeline through busy while it iterates.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        request: capture op/opa/opb (accepted only while idle)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa          multiplicand / dividend (rs)
//   opb          multiplier / divisor (rt)
//   cancel       pipeline flush: abort an iterating operation, no write
//   busy         high whenever not idle (EX stall)
//   done         one-cycle completion pulse
//   div_by_zero  pulse with done for a divide by zero
//   wehi/welo    HI/LO write enables (equal to done)
//   wdatahi/lo   HI/LO write data, zero when no write is issued
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             wehi,
  output logic [WIDTH-1:0] wdatahi,
  output logic             welo,
  output logic [WIDTH-1:0] wdatalo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two's complement negation of v when neg is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic neg);
    if (neg) begin
      neg_if = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      neg_if = v;
    end
  endfunction

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             sgn_a_q, sgn_a_d;
  logic             sgn_b_q, sgn_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fin_q, fin_d;     // all iterations done, sign fix-up pending
  logic [2*WIDTH-1:0] acc_q, acc_d;   // mul: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0] opnd_q, opnd_d;   // mul: |multiplicand|; div: |divisor|
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic               sgn_a_s, sgn_b_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_sh_s;
  logic [WIDTH:0]     div_trial_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Operand signs only matter for the signed opcodes (op[0] == 0).
  assign sgn_a_s = ~op[0] & opa[WIDTH-1];
  assign sgn_b_s = ~op[0] & opb[WIDTH-1];
  assign mag_a_s = neg_if(opa, sgn_a_s);
  assign mag_b_s = neg_if(opb, sgn_b_s);

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

  // Restoring step: shift next dividend bit into the remainder, trial
  // subtract, keep the difference and set the quotient bit if non-negative.
  assign div_sh_s    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial_s = div_sh_s - {1'b0, opnd_q};
  assign div_ge_s    = ~div_trial_s[WIDTH];
  assign div_next_s  = {(div_ge_s ? div_trial_s[WIDTH-1:0] : div_sh_s[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge_s};

  // Sign fix-up of the magnitude results. Most-negative / -1 falls out
  // naturally: quotient magnitude 2^(WIDTH-1) negates to itself.
  assign prod_s = (sgn_a_q ^ sgn_b_q) ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
  assign quo_s  = neg_if(acc_q[WIDTH-1:0], sgn_a_q ^ sgn_b_q);
  assign rem_s  = neg_if(acc_q[2*WIDTH-1:WIDTH], sgn_a_q);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sgn_a_d  = sgn_a_q;
    sgn_b_d  = sgn_b_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          sgn_a_d  = sgn_a_s;
          sgn_b_d  = sgn_b_s;
          cnt_d    = CW'(WIDTH - 1);
          fin_d    = 1'b0;
          if (op[1] && (opb == {WIDTH{1'b0}})) begin
            // Divide by zero completes without iterating.
            state_d = S_DONE;
            hi_d    = opa;
            lo_d    = {WIDTH{1'b1}};
            dbz_d   = 1'b1;
          end else if (op[1]) begin
            state_d = S_RUN;
            acc_d   = {{WIDTH{1'b0}}, mag_a_s};
            opnd_d  = mag_b_s;
            dbz_d   = 1'b0;
          end else begin
            state_d = S_RUN;
            acc_d   = {{WIDTH{1'b0}}, mag_b_s};
            opnd_d  = mag_a_s;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (fin_q) begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = rem_s;
            lo_d = quo_s;
          end else begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end
        end else begin
          acc_d = is_div_q ? div_next_s : mul_next_s;
          if (cnt_q == {CW{1'b0}}) begin
            fin_d = 1'b1;
          end else begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DONE: begin
        // cancel is ignored here: the instruction has already retired.
        state_d = S_IDLE;
        dbz_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      fin_q    <= 1'b0;
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sgn_a_q  <= sgn_a_d;
      sgn_b_q  <= sgn_b_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign wehi        = done;
  assign welo        = done;
  assign div_by_zero = done & dbz_q;
  assign wdatahi     = done ? hi_q : {WIDTH{1'b0}};
  assign wdatalo     = done ? lo_q : {WIDTH{1'b0}};

endmodule
